game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer. Owns the 4-bit `state` that drives the screen/object renderer and the per-stage draw logic.
- Consumes one-pulse button events and gameplay events (stage clear, player hit). Advances TITLE/STAFF/STAGE/SUCCESS/FAIL screens.
- Runs the per-stage countdown timer and the lives counter, and auto-advances success screens after a fixed dwell.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per game-second tick; minimum 2.
- STAGE_SEC, 60: countdown value loaded on stage entry, in seconds; range 1..127.
- SUCCESS_SEC, 3: dwell on SUCCESS1 and SUCCESS2 before auto-advance; range 1..15.
- LIVES_INIT, 3: lives loaded when leaving TITLE; range 1..3.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- btn_start, input, 1: one-cycle pulse, debounced upstream.
- btn_staff, input, 1: one-cycle pulse, debounced upstream.
- stage_clear, input, 1: one-cycle pulse; player reached the unlocked door.
- player_hit, input, 1: one-cycle pulse; player touched the boss.
- state, output, 4: current screen. Encoding: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
- time_left, output, 7: remaining stage seconds.
- lives, output, 2: remaining lives.
- state_chg, output, 1: high for exactly the first cycle a new state value is visible.

Behaviour:
- Reset (async, immediate): state=TITLE, time_left=0, lives=0, state_chg=0, prescaler=0, dwell=0. Reset mid-stage abandons all progress.
- All outputs are registered. An event sampled at edge N takes effect in the outputs after edge N.
- Prescaler:
  - Counts 0..TICK_DIV-1. sec_tick is asserted when count==TICK_DIV-1, then the count wraps to 0.
  - Forced to 0 on every state transition, so the first tick arrives TICK_DIV cycles after entry.
- TITLE:
  - btn_start -> STAGE1; lives=LIVES_INIT, time_left=STAGE_SEC.
  - btn_staff -> STAFF.
  - Both in the same cycle: start wins.
- STAFF: btn_start or btn_staff -> TITLE.
- STAGEn (n=1..3), evaluated in priority order each cycle:
  1. stage_clear -> SUCCESSn. time_left and lives freeze.
  2. player_hit: if lives==1, lives=0 and go to FAIL; else lives-1.
  3. sec_tick: if time_left==1, time_left=0 and go to FAIL; else time_left-1.
  - Hit and tick in the same cycle: both decrements apply, and FAIL results if either reaches 0.
  - Clear beats any simultaneous hit or timeout. No change is applied to lives or time_left in that case.
  - Buttons are ignored.
- SUCCESS1 / SUCCESS2:
  - Dwell counter is cleared on entry and increments on each sec_tick.
  - Dwell reaching SUCCESS_SEC -> next stage (STAGE2 / STAGE3).
  - btn_start skips the dwell immediately.
  - On exit, time_left reloads to STAGE_SEC; lives is carried over.
- SUCCESS3: btn_start -> TITLE. No auto-advance.
- FAIL: btn_start -> TITLE.
- Entering TITLE clears time_left and lives to 0.
- Gameplay pulses (stage_clear, player_hit) are ignored outside STAGEn.
- Illegal state values 9..15 (e.g. SEU) return to TITLE on the next edge, with state_chg=1.
- time_left never underflows below 0. lives never underflows below 0.
- state_chg is registered as (next_state != state). It is never high for two consecutive cycles unless two consecutive transitions occur.

Test Plan:
All scenarios use TICK_DIV=4, STAGE_SEC=5, SUCCESS_SEC=2, LIVES_INIT=3.

1. Reset then btn_start: state 0->2, time_left=5, lives=3, state_chg=1 for one cycle. Idle for 20 cycles: time_left steps 4,3,2,1 at 4-cycle intervals, then at cycle 20 time_left=0 and state=8.
2. STAGE1 with three player_hit pulses spaced 1 cycle apart: lives 2, then 1, then 0 with state=8. A 4th hit changes nothing. btn_start -> state=0, lives=0.
3. STAGE1, stage_clear and player_hit in the same cycle: state=3, lives stays 3. After 8 cycles, state=4, time_left=5, lives=3.
4. SUCCESS2 with btn_start 1 cycle after entry: state=6 on the next edge, and the dwell is not waited out. STAGE3 stage_clear -> state=7. Idle for 100 cycles: state stays 7. btn_start -> 0.
5. TITLE, btn_start and btn_staff in the same cycle: state=2. Separately, btn_staff from TITLE -> 1, then btn_staff -> 0.
6. Assert rst asynchronously mid-STAGE2 (between edges): state=0, time_left=0, lives=0 immediately, without waiting for a clock edge. Force state=12: the next edge gives state=0 and state_chg=1.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//
// Top-level game sequencer. It owns the current screen value that the
// renderer and the per-stage draw logic consume. It also runs the per-stage
// countdown, the lives counter and the timed dwell on the success screens.
//
// Parameters:
//   TICK_DIV    - clk cycles per game-second tick (>= 2)
//   STAGE_SEC   - countdown loaded on stage entry, seconds (1..127)
//   SUCCESS_SEC - dwell on SUCCESS1/SUCCESS2 before auto-advance (1..15)
//   LIVES_INIT  - lives loaded when leaving TITLE (1..3)
//
// Ports:
//   clk         - system clock
//   rst         - asynchronous, active-high reset
//   btn_start   - one-cycle start button pulse (debounced upstream)
//   btn_staff   - one-cycle staff button pulse (debounced upstream)
//   stage_clear - one-cycle pulse: player reached the unlocked door
//   player_hit  - one-cycle pulse: player touched the boss
//   state       - current screen (TITLE=0 .. SUCCESS3=7, FAIL=8)
//   time_left   - remaining stage seconds
//   lives       - remaining lives
//   state_chg   - high for the first cycle a new state value is visible
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int STAGE_SEC   = 60,
   parameter int SUCCESS_SEC = 3,
   parameter int LIVES_INIT  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_staff,
   input  logic       stage_clear,
   input  logic       player_hit,
   output logic [3:0] state,
   output logic [6:0] time_left,
   output logic [1:0] lives,
   output logic       state_chg
);

   typedef enum logic [3:0] {
      S_TITLE    = 4'd0,
      S_STAFF    = 4'd1,
      S_STAGE1   = 4'd2,
      S_SUCCESS1 = 4'd3,
      S_STAGE2   = 4'd4,
      S_SUCCESS2 = 4'd5,
      S_STAGE3   = 4'd6,
      S_SUCCESS3 = 4'd7,
      S_FAIL     = 4'd8
   } state_t;

   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [6:0]     TIME_LOAD  = 7'(STAGE_SEC);
   localparam logic [3:0]     DWELL_DONE = 4'(SUCCESS_SEC);
   localparam logic [1:0]     LIVES_LOAD = 2'(LIVES_INIT);

   // The state register is kept as raw bits rather than the enum type so that
   // an upset into an unused encoding (9..15) is representable and recovered.
   logic [3:0]    cur_state;
   logic [PW-1:0] presc;
   logic [3:0]    dwell;

   state_t        next_state;
   logic [6:0]    next_time;
   logic [1:0]    next_lives;
   logic [3:0]    next_dwell;
   logic [PW-1:0] next_presc;
   logic          sec_tick;
   logic          state_change;
   logic          lives_out;
   logic          time_out;

   // Index of the screen that follows a stage or success screen.
   function automatic state_t step_state(input logic [3:0] s);
      return state_t'(s + 4'd1);
   endfunction

   assign state = cur_state;

   // Game-second prescaler: terminal count produces sec_tick and wraps.
   always_comb begin
      sec_tick = (presc == PRESC_LAST);
      if (sec_tick) begin
         next_presc = '0;
      end else begin
         next_presc = presc + PW'(1);
      end
   end

   // Next-state, countdown, lives and dwell decisions.
   always_comb begin
      next_state = state_t'(cur_state);
      next_time  = time_left;
      next_lives = lives;
      next_dwell = dwell;
      lives_out  = 1'b0;
      time_out   = 1'b0;

      case (cur_state)
         S_TITLE: begin
            // Start wins over staff when both arrive together.
            if (btn_start) begin
               next_state = S_STAGE1;
               next_time  = TIME_LOAD;
               next_lives = LIVES_LOAD;
            end else if (btn_staff) begin
               next_state = S_STAFF;
            end else begin
               next_state = S_TITLE;
            end
         end

         S_STAFF: begin
            if (btn_start || btn_staff) begin
               next_state = S_TITLE;
               next_time  = 7'd0;
               next_lives = 2'd0;
            end else begin
               next_state = S_STAFF;
            end
         end

         S_STAGE1, S_STAGE2, S_STAGE3: begin
            // A clear freezes time and lives even if a hit or timeout
            // lands in the same cycle.
            if (stage_clear) begin
               next_state = step_state(cur_state);
            end else begin
               // Hit and timeout are evaluated independently so both
               // decrements apply when they coincide.
               if (player_hit) begin
                  if (lives <= 2'd1) begin
                     next_lives = 2'd0;
                     lives_out  = 1'b1;
                  end else begin
                     next_lives = lives - 2'd1;
                  end
               end else begin
                  next_lives = lives;
               end

               if (sec_tick) begin
                  if (time_left <= 7'd1) begin
                     next_time = 7'd0;
                     time_out  = 1'b1;
                  end else begin
                     next_time = time_left - 7'd1;
                  end
               end else begin
                  next_time = time_left;
               end

               if (lives_out || time_out) begin
                  next_state = S_FAIL;
               end else begin
                  next_state = state_t'(cur_state);
               end
            end
         end

         S_SUCCESS1, S_SUCCESS2: begin
            // Start skips the remaining dwell; otherwise the dwell counts
            // seconds until it reaches the configured value.
            if (btn_start || (sec_tick && ((dwell + 4'd1) == DWELL_DONE))) begin
               next_state = step_state(cur_state);
               next_time  = TIME_LOAD;
            end else if (sec_tick) begin
               next_dwell = dwell + 4'd1;
            end else begin
               next_dwell = dwell;
            end
         end

         S_SUCCESS3, S_FAIL: begin
            if (btn_start) begin
               next_state = S_TITLE;
               next_time  = 7'd0;
               next_lives = 2'd0;
            end else begin
               next_state = state_t'(cur_state);
            end
         end

         default: begin
            // Unused encodings fall back to the title screen.
            next_state = S_TITLE;
            next_time  = 7'd0;
            next_lives = 2'd0;
            next_dwell = 4'd0;
         end
      endcase

      state_change = (4'(next_state) != cur_state);
   end

   // Registered state, counters and outputs; async reset abandons all progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= 4'(S_TITLE);
         time_left <= 7'd0;
         lives     <= 2'd0;
         state_chg <= 1'b0;
         presc     <= '0;
         dwell     <= 4'd0;
      end else begin
         cur_state <= 4'(next_state);
         time_left <= next_time;
         lives     <= next_lives;
         state_chg <= state_change;
         // Every transition restarts the second and the dwell so the first
         // tick in a new screen comes a full TICK_DIV cycles after entry.
         if (state_change) begin
            presc <= '0;
            dwell <= 4'd0;
         end else begin
            presc <= next_presc;
            dwell <= next_dwell;
         end
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
//
// Directed-vector bench for game_flow_ctrl. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor pops one entry after
// every rising edge and compares (-1 marks a field that is not checked).
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

   localparam int TD  = 4;
   localparam int SS  = 5;
   localparam int SUC = 2;
   localparam int LI  = 3;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       btn_start   = 1'b0;
   logic       btn_staff   = 1'b0;
   logic       stage_clear = 1'b0;
   logic       player_hit  = 1'b0;
   logic [3:0] state;
   logic [6:0] time_left;
   logic [1:0] lives;
   logic       state_chg;

   int total = 0;
   int bad   = 0;
   int vid   = 0;

   typedef struct {
      int id;
      int st;
      int tl;
      int lv;
      int chg;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   game_flow_ctrl #(
      .TICK_DIV   (TD),
      .STAGE_SEC  (SS),
      .SUCCESS_SEC(SUC),
      .LIVES_INIT (LI)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_staff  (btn_staff),
      .stage_clear(stage_clear),
      .player_hit (player_hit),
      .state      (state),
      .time_left  (time_left),
      .lives      (lives),
      .state_chg  (state_chg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int id, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic cyc(input logic s, input logic f, input logic c, input logic h,
                      input int st, input int tl, input int lv, input int chg);
      exp_t e;
      @(negedge clk);
      btn_start   = s;
      btn_staff   = f;
      stage_clear = c;
      player_hit  = h;
      e.id  = vid;
      e.st  = st;
      e.tl  = tl;
      e.lv  = lv;
      e.chg = chg;
      sbq.push_back(e);
      vid++;
   endtask

   // Monitor: compare registered outputs shortly after every rising edge.
   always @(posedge clk) begin
      #1;
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         if (mon_e.st  >= 0) check("state",     mon_e.id, int'(state),     mon_e.st);
         if (mon_e.tl  >= 0) check("time_left", mon_e.id, int'(time_left), mon_e.tl);
         if (mon_e.lv  >= 0) check("lives",     mon_e.id, int'(lives),     mon_e.lv);
         if (mon_e.chg >= 0) check("state_chg", mon_e.id, int'(state_chg), mon_e.chg);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_state", -1, int'(state),     0);
      check("rst_time",  -1, int'(time_left), 0);
      check("rst_lives", -1, int'(lives),     0);
      check("rst_chg",   -1, int'(state_chg), 0);
      rst = 1'b0;

      // 1: start, then let the countdown run out.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 5, 3, 1);
      for (int i = 1; i <= 20; i++) begin
         if (i < 20) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2, 5 - (i / 4), 3, 0);
         else        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 3, 1);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 3, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);

      // 2: three hits with a gap, one tick in between, then a stray hit.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 5, 3, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2, 5, 2, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 2, 5, 2, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2, 5, 1, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 2, 4, 1, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);

      // 3: clear beats a simultaneous hit; dwell auto-advances after 2 s.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 5, 3, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 3, 5, 3, 1);
      for (int i = 1; i <= 8; i++) begin
         if (i < 8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3, 5, 3, 0);
         else       cyc(1'b0, 1'b0, 1'b0, 1'b0, 4, 5, 3, 1);
      end

      // 4: start skips SUCCESS2 dwell; SUCCESS3 never auto-advances.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5, 5, 3, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 6, 5, 3, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 7, 5, 3, 1);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 7, 5, 3, 0);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);

      // 5: staff screen round trips, start+staff together, buttons in stage.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 2, 5, 3, 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 2, 5, 3, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 3, 5, 3, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4, 5, 3, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4, 5, 3, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4, 5, 2, 0);

      // 6: asynchronous reset between edges mid-STAGE2.
      @(negedge clk);
      btn_start   = 1'b0;
      btn_staff   = 1'b0;
      stage_clear = 1'b0;
      player_hit  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_state", -2, int'(state),     0);
      check("async_time",  -2, int'(time_left), 0);
      check("async_lives", -2, int'(lives),     0);
      check("async_chg",   -2, int'(state_chg), 0);
      @(negedge clk);
      rst = 1'b0;

      // Illegal encoding recovers to TITLE on the next edge.
      @(negedge clk);
      force dut.cur_state = 4'd12;
      @(posedge clk);
      #1;
      check("illegal_chg", -3, int'(state_chg), 1);
      release dut.cur_state;
      @(posedge clk);
      #1;
      check("illegal_state", -3, int'(state),     0);
      check("illegal_time",  -3, int'(time_left), 0);
      check("illegal_lives", -3, int'(lives),     0);

      @(negedge clk);
      check("sb_drain", -4, sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
